flash_ram_writer: RTL and testbench

FLASH_RAM_WRITER -- requirements
Module: flash_ram_writer

---
 rtl/flash_ram_pkg.sv | 14 +
 rtl/byte_lane_packer.sv | 39 +++
 rtl/flash_ram_writer.sv | 124 ++++++++++++
 tb/tb_flash_ram_writer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_ram_pkg.sv
// Shared definitions for the SPI-flash-to-RAM writer: FSM encoding and lane geometry.
package flash_ram_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/byte_lane_packer.sv
// Packs a byte stream little-endian into a 32-bit word with a matching byteenable mask.
module byte_lane_packer
    import flash_ram_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic [7:0]           i_byte,
    output logic [8*LANES-1:0]   o_data,
    output logic [LANES-1:0]     o_be,
    output logic [LANE_W-1:0]    o_lane
);

    logic [8*LANES-1:0] r_data;
    logic [LANES-1:0]   r_be;
    logic [LANE_W-1:0]  r_lane;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
            r_be   <= '0;
            r_lane <= '0;
        end else if (i_clear) begin
            r_data <= '0;
            r_be   <= '0;
            r_lane <= '0;
        end else if (i_load) begin
            r_data[8*r_lane +: 8] <= i_byte;
            r_be[r_lane]          <= 1'b1;
            r_lane                <= r_lane + 1'b1;
        end
    end

    assign o_data = r_data;
    assign o_be   = r_be;
    assign o_lane = r_lane;

endmodule

// File: rtl/flash_ram_writer.sv
// Copies a counted byte stream from the SPI flash reader into on-chip RAM as 32-bit
// Avalon-MM writes, one word per RAM address, with a partial final word masked by byteenable.
module flash_ram_writer
    import flash_ram_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ctl_start,
    input  logic [ADDR_W-1:0] ctl_base,
    input  logic [CNT_W-1:0]  ctl_count,
    output logic              ctl_busy,
    output logic              ctl_done,
    input  logic [7:0]        st_data,
    input  logic              st_valid,
    output logic              st_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    output logic              avm_chipselect,
    output logic              avm_write,
    input  logic              avm_waitrequest,
    output logic [1:0]        o_dbg_state
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_count;
    logic                r_busy;
    logic                r_done;
    logic                r_ready;
    logic                r_write;

    logic                w_accept;
    logic                w_last;
    logic                w_clear;
    logic [LANE_W-1:0]   w_lane;

    // Streaming handshake: a byte moves on a rising edge where st_valid and st_ready are both high.
    assign w_accept = r_ready & st_valid;
    assign w_last   = (w_lane == LANE_W'(LANES - 1)) || (r_count == CNT_W'(1));
    assign w_clear  = ((r_state == S_IDLE) && ctl_start) ||
                      ((r_state == S_WRITE) && !avm_waitrequest);

    byte_lane_packer u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_clear),
        .i_load  (w_accept),
        .i_byte  (st_data),
        .o_data  (avm_writedata),
        .o_be    (avm_byteenable),
        .o_lane  (w_lane)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
            r_write <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ctl_start) begin
                        r_addr  <= ctl_base;
                        r_count <= ctl_count;
                        r_busy  <= 1'b1;
                        if (ctl_count == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_FILL;
                            r_ready <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_count <= r_count - 1'b1;
                        if (w_last) begin
                            r_state <= S_WRITE;
                            r_ready <= 1'b0;
                            r_write <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    // Address, data and byteenable stay frozen until the slave drops waitrequest.
                    if (!avm_waitrequest) begin
                        r_write <= 1'b0;
                        r_addr  <= r_addr + 1'b1;
                        if (r_count != '0) begin
                            r_state <= S_FILL;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ctl_busy       = r_busy;
    assign ctl_done       = r_done;
    assign st_ready       = r_ready;
    assign avm_address    = r_addr;
    assign avm_write      = r_write;
    assign avm_chipselect = r_write;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_flash_ram_writer.sv
// Directed bench for flash_ram_writer: table of transfers plus hand sequences for
// zero count and mid-transfer reset; RAM writes are checked against a word-packing model.
module tb_flash_ram_writer;

    localparam int AW = 11;
    localparam int CW = 13;
    localparam int WW = AW + 4 + 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ctl_start = 1'b0;
    logic [AW-1:0] ctl_base = '0;
    logic [CW-1:0] ctl_count = '0;
    logic          ctl_busy, ctl_done;
    logic [7:0]    st_data = '0;
    logic          st_valid = 1'b0;
    logic          st_ready;
    logic [AW-1:0] avm_address;
    logic [3:0]    avm_byteenable;
    logic [31:0]   avm_writedata;
    logic          avm_chipselect, avm_write;
    logic          avm_waitrequest = 1'b0;
    logic [1:0]    dbg_state;

    flash_ram_writer #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ctl_start       (ctl_start),
        .ctl_base        (ctl_base),
        .ctl_count       (ctl_count),
        .ctl_busy        (ctl_busy),
        .ctl_done        (ctl_done),
        .st_data         (st_data),
        .st_valid        (st_valid),
        .st_ready        (st_ready),
        .avm_address     (avm_address),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_waitrequest (avm_waitrequest),
        .o_dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [WW-1:0] exp_q[$];
    logic [7:0]    src_q[$];
    bit            gap_mode = 1'b0;
    int            wait_left = 0;
    int            writes_seen = 0;
    int            done_cnt = 0;
    int            acc_cnt = 0;
    int            cyc = 0;
    logic [WW-1:0] got_first = '0;
    logic [WW-1:0] got_last = '0;

    logic          prev_v = 1'b0, prev_rdy = 1'b0, prev_wr = 1'b0, prev_wait = 1'b0;
    logic [WW-1:0] prev_word = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Stream driver, waitrequest generator and write monitor, all evaluated on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_v = 1'b0; prev_rdy = 1'b0; prev_wr = 1'b0; prev_wait = 1'b0;
            st_valid = 1'b0;
            avm_waitrequest = 1'b0;
        end else begin
            if (prev_wr && !prev_wait) begin
                writes_seen++;
                if (writes_seen == 1) got_first = prev_word;
                got_last = prev_word;
                if (exp_q.size() == 0) chk("unexpected_write", 64'(prev_word), 64'h0);
                else chk("ram_write", 64'(prev_word), 64'(exp_q.pop_front()));
            end
            if (prev_v && prev_rdy && src_q.size() > 0) begin
                void'(src_q.pop_front());
                acc_cnt++;
            end
            cyc++;
            if (src_q.size() > 0 && (!gap_mode || (cyc % 3) == 0)) begin
                st_valid = 1'b1;
                st_data  = src_q[0];
            end else begin
                st_valid = 1'b0;
            end
            avm_waitrequest = avm_write && (wait_left > 0);
            if (avm_waitrequest) wait_left--;
            if (avm_write) begin
                if (exp_q.size() == 0) chk("write_with_no_expected_word", 64'(avm_write), 64'h0);
                else chk("held_word", 64'({avm_address, avm_byteenable, avm_writedata}), 64'(exp_q[0]));
                chk("ready_low_in_write", 64'(st_ready), 64'h0);
                chk("chipselect_with_write", 64'(avm_chipselect), 64'h1);
            end
            if (ctl_done) begin
                done_cnt++;
                chk("busy_low_at_done", 64'(ctl_busy), 64'h0);
            end
            prev_v    = st_valid;
            prev_rdy  = st_ready;
            prev_wr   = avm_write;
            prev_wait = avm_waitrequest;
            prev_word = {avm_address, avm_byteenable, avm_writedata};
        end
    end

    typedef struct {
        logic [AW-1:0] base;
        logic [CW-1:0] count;
        logic [7:0]    first;
        bit            gap;
        int            wait_n;
        bit            poke;
        int            exp_writes;
        logic [31:0]   exp_first_data;
        logic [AW-1:0] exp_last_addr;
        logic [3:0]    exp_last_be;
    } vec_t;

    vec_t vecs[7];

    task automatic build_expect(input logic [AW-1:0] base, input int count, input logic [7:0] first);
        logic [31:0] d;
        logic [3:0]  be;
        logic [AW-1:0] a;
        exp_q.delete();
        src_q.delete();
        for (int k = 0; k < count; k++) src_q.push_back(8'(first + 8'(k)));
        for (int w = 0; w * 4 < count; w++) begin
            d = '0;
            be = '0;
            for (int l = 0; l < 4; l++) begin
                if (w * 4 + l < count) begin
                    d[8*l +: 8] = 8'(first + 8'(w * 4 + l));
                    be[l] = 1'b1;
                end
            end
            a = base + AW'(w);
            exp_q.push_back({a, be, d});
        end
    endtask

    task automatic run_xfer(input vec_t v);
        int d0;
        build_expect(v.base, int'(v.count), v.first);
        gap_mode = v.gap;
        wait_left = v.wait_n;
        writes_seen = 0;
        d0 = done_cnt;
        @(negedge clk); #1;
        ctl_base = v.base; ctl_count = v.count; ctl_start = 1'b1;
        @(negedge clk); #1;
        ctl_start = 1'b0;
        chk("busy_after_start", 64'(ctl_busy), 64'h1);
        if (v.poke) begin
            repeat (2) @(negedge clk);
            #1 ctl_start = 1'b1; ctl_base = 11'h1F0; ctl_count = 13'd2;
            @(negedge clk); #1 ctl_start = 1'b0;
        end
        for (int c = 0; c < 3000 && done_cnt == d0; c++) begin
            @(negedge clk); #1;
        end
        if (done_cnt == d0) chk("done_timeout", 64'h0, 64'h1);
        repeat (3) @(negedge clk);
        #1;
        chk("done_pulses", 64'(done_cnt - d0), 64'h1);
        chk("exp_words_left", 64'(exp_q.size()), 64'h0);
        chk("bytes_left", 64'(src_q.size()), 64'h0);
        chk("write_count", 64'(writes_seen), 64'(v.exp_writes));
        chk("first_word_data", 64'(got_first[31:0]), 64'(v.exp_first_data));
        chk("last_word_addr", 64'(got_last[WW-1 -: AW]), 64'(v.exp_last_addr));
        chk("last_word_be", 64'(got_last[35:32]), 64'(v.exp_last_be));
        chk("busy_idle", 64'(ctl_busy), 64'h0);
        chk("state_idle", 64'(dbg_state), 64'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  64'(ctl_busy), 64'h0);
        chk({tag, "_done"},  64'(ctl_done), 64'h0);
        chk({tag, "_ready"}, 64'(st_ready), 64'h0);
        chk({tag, "_write"}, 64'({avm_write, avm_chipselect}), 64'h0);
        chk({tag, "_addr"},  64'(avm_address), 64'h0);
        chk({tag, "_be"},    64'(avm_byteenable), 64'h0);
        chk({tag, "_data"},  64'(avm_writedata), 64'h0);
        chk({tag, "_state"}, 64'(dbg_state), 64'h0);
    endtask

    initial begin
        int d0;
        int w0;
        vecs[0] = '{11'h010, 13'd8, 8'h01, 1'b0, 0, 1'b0, 2, 32'h04030201, 11'h011, 4'b1111};
        vecs[1] = '{11'h7FF, 13'd6, 8'h11, 1'b0, 0, 1'b0, 2, 32'h14131211, 11'h000, 4'b0011};
        vecs[2] = '{11'h020, 13'd5, 8'hA1, 1'b0, 0, 1'b0, 2, 32'hA4A3A2A1, 11'h021, 4'b0001};
        vecs[3] = '{11'h020, 13'd5, 8'hA1, 1'b1, 0, 1'b0, 2, 32'hA4A3A2A1, 11'h021, 4'b0001};
        vecs[4] = '{11'h040, 13'd4, 8'h55, 1'b0, 5, 1'b0, 1, 32'h58575655, 11'h040, 4'b1111};
        vecs[5] = '{11'h003, 13'd1, 8'hEE, 1'b0, 0, 1'b0, 1, 32'h000000EE, 11'h003, 4'b0001};
        vecs[6] = '{11'h100, 13'd7, 8'h30, 1'b0, 0, 1'b1, 2, 32'h33323130, 11'h101, 4'b0111};

        #1;
        chk_reset_outputs("reset");
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;

        foreach (vecs[i]) run_xfer(vecs[i]);

        // Zero-length transfer: done two edges after the start, never a write.
        exp_q.delete();
        src_q.delete();
        d0 = done_cnt;
        w0 = writes_seen;
        @(negedge clk); #1;
        ctl_base = 11'h200; ctl_count = '0; ctl_start = 1'b1;
        @(negedge clk); #1;
        ctl_start = 1'b0;
        chk("zero_busy", 64'(ctl_busy), 64'h1);
        chk("zero_done_early", 64'(ctl_done), 64'h0);
        @(negedge clk); #1;
        chk("zero_done", 64'(ctl_done), 64'h1);
        @(negedge clk); #1;
        chk("zero_done_once", 64'(ctl_done), 64'h0);
        chk("zero_no_write", 64'(writes_seen), 64'(w0));
        chk("zero_done_count", 64'(done_cnt - d0), 64'h1);

        // Reset after three of eight bytes: no write, no done, partial word dropped.
        build_expect(11'h050, 8, 8'h61);
        exp_q.delete();
        gap_mode = 1'b0;
        wait_left = 0;
        writes_seen = 0;
        acc_cnt = 0;
        d0 = done_cnt;
        @(negedge clk); #1;
        ctl_base = 11'h050; ctl_count = 13'd8; ctl_start = 1'b1;
        @(negedge clk); #1;
        ctl_start = 1'b0;
        for (int c = 0; c < 100 && acc_cnt < 3; c++) begin
            @(negedge clk); #1;
        end
        chk("abort_bytes_taken", 64'(acc_cnt), 64'h3);
        reset_n = 1'b0;
        src_q.delete();
        #1;
        chk_reset_outputs("abort");
        repeat (3) @(negedge clk);
        #1;
        chk("abort_no_write", 64'(writes_seen), 64'h0);
        chk("abort_no_done", 64'(done_cnt - d0), 64'h0);
        reset_n = 1'b1;
        run_xfer(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
